// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC, fetches over a req/ack handshake and holds the instruction for the controller.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic [31:0] instr_count,
    output logic        pc_misalign
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] CNT_STEP   = XLEN'(1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_GAP   = 2'd2
`ifdef PC_MISALIGN_TRAP_EN
        , S_HALT = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] ir_pc_q, ir_pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_count_q, instr_count_d;
    logic [XLEN-1:0] redir_addr_q, redir_addr_d;
    logic            ir_valid_q, ir_valid_d;
    logic            redir_pend_q, redir_pend_d;
    logic            squash_q, squash_d;
    logic            redir_take;
    logic [XLEN-1:0] redir_sel;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            pc_plus4_q    <= '0;
            instr_count_q <= '0;
            redir_addr_q  <= '0;
            ir_valid_q    <= 1'b0;
            redir_pend_q  <= 1'b0;
            squash_q      <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_count_q <= instr_count_d;
            redir_addr_q  <= redir_addr_d;
            ir_valid_q    <= ir_valid_d;
            redir_pend_q  <= redir_pend_d;
            squash_q      <= squash_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    // Next-state: fetch, execute-wait, one-cycle refetch gap after a squash
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_count_d = instr_count_q;
        redir_addr_d  = redir_addr_q;
        ir_valid_d    = ir_valid_q;
        redir_pend_d  = redir_pend_q;
        squash_d      = squash_q;
        redir_take    = 1'b0;
        redir_sel     = redir_addr_q;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif

        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    if (redir_valid || squash_q) begin
                        redir_take = 1'b1;
                        redir_sel  = redir_valid ? redir_target : redir_addr_q;
                        squash_d   = 1'b0;
                        state_d    = S_GAP;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_pc_d    = pc_q;
                        pc_plus4_d = pc_q + PC_STEP;
                        ir_valid_d = 1'b1;
                        state_d    = S_EXEC;
                    end
                end else if (redir_valid) begin
                    squash_d     = 1'b1;
                    redir_addr_d = redir_target;
                end
            end
            S_EXEC: begin
                if (instr_done && ir_valid_q) begin
                    ir_valid_d    = 1'b0;
                    redir_pend_d  = 1'b0;
                    instr_count_d = instr_count_q + CNT_STEP;
                    state_d       = S_FETCH;
                    if (redir_valid) begin
                        redir_take = 1'b1;
                        redir_sel  = redir_target;
                    end else if (redir_pend_q) begin
                        redir_take = 1'b1;
                        redir_sel  = redir_addr_q;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (redir_valid) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = redir_target;
                end
            end
            S_GAP: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // Redirect target is word-aligned unless the trap catches a misaligned one
        if (redir_take) begin
            pc_d = redir_sel & ALIGN_MASK;
`ifdef PC_MISALIGN_TRAP_EN
            if (redir_sel[1:0] != 2'b00) begin
                pc_d       = redir_sel;
                misalign_d = 1'b1;
                state_d    = S_HALT;
            end
`endif
        end
    end

    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign ir_pc       = ir_pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign instr_count = instr_count_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver/memory model pushes expected fetches and
// instruction latches; a negedge monitor pops and compares when the DUT presents them.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] ir_pc;
    logic [31:0] pc_plus4;
    logic        instr_done;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] instr_count;
    logic        pc_misalign;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] nxt;
    } ir_exp_t;

    logic [31:0] exp_fetch[$];
    ir_exp_t     exp_ir[$];

    logic [31:0] model_pc;
    logic [31:0] model_ir;
    logic [31:0] model_count;
    bit          model_halt;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_pc        (ir_pc),
        .pc_plus4     (pc_plus4),
        .instr_done   (instr_done),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .instr_count  (instr_count),
        .pc_misalign  (pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference rule for a redirect reaching the PC
    function automatic void take_redirect(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        model_pc   = t;
        model_halt = (t[1:0] != 2'b00);
`else
        model_pc   = t & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
`ifdef PC_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 16) begin
            cyc();
            n++;
        end
        chk1("req_wait", imem_req, 1'b1);
    endtask

    // One fetch: ack after dly cycles, optionally squashed by a redirect at cycle sq_at
    task automatic do_fetch(input int dly, input bit sq, input int sq_at,
                            input logic [31:0] sq_tgt, input logic [31:0] rdata);
        ir_exp_t e;
        exp_fetch.push_back(model_pc);
        wait_req();
        for (int i = 0; i <= dly; i++) begin
            if (sq && i == sq_at) begin
                redir_valid  = 1'b1;
                redir_target = sq_tgt;
            end
            instr_done = ($urandom_range(0, 3) == 0);
            if (i == dly) begin
                imem_ack   = 1'b1;
                imem_rdata = rdata;
                if (!sq) begin
                    e.instr  = rdata;
                    e.addr   = model_pc;
                    e.nxt    = model_pc + 32'd4;
                    exp_ir.push_back(e);
                    model_ir = rdata;
                end
            end
            cyc();
            redir_valid = 1'b0;
            imem_ack    = 1'b0;
            instr_done  = 1'b0;
        end
        chk1("ir_valid_after_ack", ir_valid, !sq);
        if (sq) begin
            take_redirect(sq_tgt);
            chk1("req_gap_after_squash", imem_req, 1'b0);
            chk32("ir_hold_on_squash", ir, model_ir);
        end
    endtask

    // One execute phase: pre wait cycles with optional redirects, then instr_done
    task automatic do_exec(input int pre, input bit r1, input logic [31:0] t1,
                           input bit r2, input logic [31:0] t2,
                           input bit rs, input logic [31:0] ts);
        bit          have = 1'b0;
        logic [31:0] tgt  = '0;
        for (int i = 0; i < pre; i++) begin
            if (r1 && i == 0) begin
                redir_valid = 1'b1; redir_target = t1; have = 1'b1; tgt = t1;
            end
            if (r2 && i == pre - 1) begin
                redir_valid = 1'b1; redir_target = t2; have = 1'b1; tgt = t2;
            end
            cyc();
            redir_valid = 1'b0;
        end
        instr_done = 1'b1;
        if (rs) begin
            redir_valid = 1'b1; redir_target = ts; have = 1'b1; tgt = ts;
        end
        cyc();
        instr_done  = 1'b0;
        redir_valid = 1'b0;
        model_count = model_count + 32'd1;
        if (have) take_redirect(tgt);
        else model_pc = model_pc + 32'd4;
        if (!model_halt) chk1("req_after_done", imem_req, 1'b1);
        chk32("instr_count", instr_count, model_count);
    endtask

    // Monitor: accepted fetches and newly latched instructions
    logic irv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ack) begin
            if (exp_fetch.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
            end else begin
                chk32("fetch_addr", imem_addr, exp_fetch.pop_front());
            end
        end
        if (ir_valid && !irv_prev) begin
            if (exp_ir.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ir_unexpected: got ir %h expected no latch", ir);
            end else begin
                ir_exp_t e;
                e = exp_ir.pop_front();
                chk32("ir", ir, e.instr);
                chk32("ir_pc", ir_pc, e.addr);
                chk32("pc_plus4", pc_plus4, e.nxt);
            end
        end
        irv_prev = ir_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        instr_done = 1'b0; redir_valid = 1'b0; redir_target = '0;
        model_pc = RST_PC; model_ir = '0; model_count = '0; model_halt = 1'b0;

        repeat (3) cyc();
        chk1("rst_req", imem_req, 1'b0);
        chk32("rst_addr", imem_addr, RST_PC);
        chk1("rst_ir_valid", ir_valid, 1'b0);
        chk32("rst_ir", ir, 32'h0);
        chk32("rst_count", instr_count, 32'h0);
        chk1("rst_misalign", pc_misalign, 1'b0);
        rst = 1'b0;
        #1;
        chk1("req_first_cycle", imem_req, 1'b1);

        // Sequential fetches
        do_fetch(2, 1'b0, 0, '0, 32'h2010_0005);
        do_exec(1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        do_fetch(0, 1'b0, 0, '0, $urandom());
        do_exec(2, 1'b0, '0, 1'b0, '0, 1'b0, '0);

        // Pending redirects in execute, single and last-wins
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(3, 1'b1, 32'h200, 1'b0, '0, 1'b0, '0);
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(3, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, '0);

        // Squash of an outstanding fetch, then wrap at top of address space
        do_fetch(2, 1'b1, 0, 32'h400, 32'hDEAD_BEEF);
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(1, 1'b0, '0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        do_fetch(2, 1'b1, 2, 32'h800, $urandom());

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            int dly;
            bit sq;
            dly = $urandom_range(0, 3);
            sq  = ($urandom_range(0, 4) == 0);
            do_fetch(dly, sq, $urandom_range(0, dly), rand_tgt(), $urandom());
            if (!sq) begin
                do_exec($urandom_range(0, 4),
                        ($urandom_range(0, 2) == 0), rand_tgt(),
                        ($urandom_range(0, 3) == 0), rand_tgt(),
                        ($urandom_range(0, 3) == 0), rand_tgt());
            end
        end

        // Reset during an outstanding fetch
        exp_fetch.push_back(model_pc);
        wait_req();
        cyc();
        rst = 1'b1;
        cyc();
        chk1("midrst_req", imem_req, 1'b0);
        chk32("midrst_addr", imem_addr, RST_PC);
        chk1("midrst_ir_valid", ir_valid, 1'b0);
        chk32("midrst_count", instr_count, 32'h0);
        exp_fetch.delete();
        model_pc = RST_PC; model_ir = '0; model_count = '0;
        rst = 1'b0;
        #1;
        chk1("midrst_req_release", imem_req, 1'b1);

        // Misaligned redirect
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(1, 1'b1, 32'h202, 1'b0, '0, 1'b0, '0);
`ifdef PC_MISALIGN_TRAP_EN
        chk1("trap_flag", pc_misalign, 1'b1);
        chk32("trap_pc", imem_addr, 32'h202);
        for (int i = 0; i < 4; i++) begin
            instr_done = 1'b1; redir_valid = 1'b1; redir_target = 32'h500;
            cyc();
            chk1("halt_req", imem_req, 1'b0);
            chk1("halt_ir_valid", ir_valid, 1'b0);
            chk1("halt_flag_sticky", pc_misalign, 1'b1);
        end
        instr_done = 1'b0; redir_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk1("trap_cleared", pc_misalign, 1'b0);
        chk1("trap_exit_req", imem_req, 1'b1);
        chk32("trap_exit_addr", imem_addr, RST_PC);
`else
        chk1("no_trap_flag", pc_misalign, 1'b0);
        do_fetch(1, 1'b0, 0, '0, $urandom());
        do_exec(0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
`endif

        repeat (2) cyc();
        chk32("fetch_queue_drained", 32'(exp_fetch.size()), 32'h0);
        chk32("ir_queue_drained", 32'(exp_ir.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
